// File: rtl/sfo_hypothesis_sweeper.sv
// sfo_hypothesis_sweeper
//
// Steps an SFO hypothesis linearly from sfo_start by sfo_step, num_hyp times.
// For every hypothesis it clears the correlator, replays one stored power
// spectrum from an external 1-cycle-latency RAM into it, waits for the
// correlation result (or gives up after TIMEOUT_CYCLES) and keeps the
// argmax. The winning SFO, correlation and index are presented on best_*.
//
// Optional feature, enabled by defining SFO_SWEEP_METADATA_EN:
//   adds metadata_in / best_metadata. metadata_in is captured together with
//   correlation_in and follows best_corr into best_metadata.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | waiting for start; best_* hold the last sweep's winner
// S_LOAD     | one cycle: correlator reset, SFO outputs carry the hypothesis
// S_STREAM   | read bins 0..2^N-1, forward each word the cycle after its read
// S_WAIT     | wait for correlation_in_valid, bounded by TIMEOUT_CYCLES
// S_COMPARE  | one cycle: update argmax, advance or finish the sweep

module sfo_hypothesis_sweeper #(
    parameter int FFT_LEN_LOG2   = 9,
    parameter int POWER_WIDTH    = 16,
    parameter int SFO_INT_WIDTH  = 9,
    parameter int SFO_FRAC_WIDTH = 16,
    parameter int CORR_WIDTH     = 26,
    parameter int HYP_CNT_WIDTH  = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                                    clk,
    input  logic                                    resetn,
    input  logic                                    start,
    input  logic [SFO_INT_WIDTH+SFO_FRAC_WIDTH-1:0] sfo_start,
    input  logic [SFO_INT_WIDTH+SFO_FRAC_WIDTH-1:0] sfo_step,
    input  logic [HYP_CNT_WIDTH-1:0]                num_hyp,
    output logic                                    bin_rd_en,
    output logic [FFT_LEN_LOG2-1:0]                 bin_rd_addr,
    input  logic [POWER_WIDTH-1:0]                  bin_rd_data,
    output logic [SFO_INT_WIDTH-1:0]                sfo_int_part,
    output logic [SFO_FRAC_WIDTH-1:0]               sfo_frac_part,
    output logic                                    correlation_reset,
    output logic                                    correlation_update,
    output logic [POWER_WIDTH-1:0]                  fft_mag_out,
    input  logic [CORR_WIDTH-1:0]                   correlation_in,
    input  logic                                    correlation_in_valid,
    output logic                                    busy,
    output logic                                    done,
    output logic [SFO_INT_WIDTH+SFO_FRAC_WIDTH-1:0] best_sfo,
    output logic [CORR_WIDTH-1:0]                   best_corr,
    output logic [HYP_CNT_WIDTH-1:0]                best_index
`ifdef SFO_SWEEP_METADATA_EN
    ,
    input  logic [2*POWER_WIDTH-1:0]                metadata_in,
    output logic [2*POWER_WIDTH-1:0]                best_metadata
`endif
);

    localparam int SFO_WIDTH     = SFO_INT_WIDTH + SFO_FRAC_WIDTH;
    localparam int BIN_CNT_WIDTH = FFT_LEN_LOG2 + 1;
    localparam int WAIT_WIDTH    = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_STREAM  = 3'd2;
    localparam logic [2:0] S_WAIT    = 3'd3;
    localparam logic [2:0] S_COMPARE = 3'd4;

    localparam logic [BIN_CNT_WIDTH-1:0] BIN_CNT_ONE = {{FFT_LEN_LOG2{1'b0}}, 1'b1};
    localparam logic [WAIT_WIDTH-1:0]    WAIT_LOAD   = WAIT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [WAIT_WIDTH-1:0]    WAIT_ONE    = WAIT_WIDTH'(1);
    localparam logic [HYP_CNT_WIDTH-1:0] HYP_ONE     = HYP_CNT_WIDTH'(1);

    logic [2:0]               state;
    logic [HYP_CNT_WIDTH-1:0] hyp_idx;
    logic [HYP_CNT_WIDTH-1:0] num_hyp_r;
    logic [SFO_WIDTH-1:0]     cur_sfo;
    logic [SFO_WIDTH-1:0]     sfo_step_r;
    logic [BIN_CNT_WIDTH-1:0] bin_cnt;
    logic                     update_r;
    logic [WAIT_WIDTH-1:0]    wait_cnt;
    logic [CORR_WIDTH-1:0]    result_r;

    logic sweep_go;
    logic sweep_empty;
    logic stream_done;
    logic last_hyp;
    logic take_best;

`ifdef SFO_SWEEP_METADATA_EN
    logic [2*POWER_WIDTH-1:0] meta_r;
`endif

    assign sweep_go    = (state == S_IDLE) && start && (num_hyp != '0);
    assign sweep_empty = (state == S_IDLE) && start && (num_hyp == '0);

    // bin_cnt reaching 2^N marks the final STREAM cycle, which only carries
    // the last forwarded word and issues no read.
    assign stream_done = bin_cnt[FFT_LEN_LOG2];
    assign last_hyp    = (hyp_idx == (num_hyp_r - HYP_ONE));

    // Hypothesis 0 always seeds the argmax; later ones must beat it strictly.
    assign take_best   = (hyp_idx == '0) || (result_r > best_corr);

    assign bin_rd_en   = (state == S_STREAM) && !stream_done;
    assign bin_rd_addr = bin_rd_en ? bin_cnt[FFT_LEN_LOG2-1:0] : '0;

    // The correlator is held cleared for as long as resetn is low.
    assign correlation_reset  = !resetn || (state == S_LOAD);
    assign correlation_update = update_r;

    // RAM output is already registered, so it is forwarded without a flop.
    assign fft_mag_out = update_r ? bin_rd_data : '0;

    assign sfo_int_part  = cur_sfo[SFO_WIDTH-1:SFO_FRAC_WIDTH];
    assign sfo_frac_part = cur_sfo[SFO_FRAC_WIDTH-1:0];

    // Sweep sequencing: state, busy and the done pulse.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (sweep_go) begin
                        busy  <= 1'b1;
                        state <= S_LOAD;
                    end else if (sweep_empty) begin
                        done <= 1'b1;
                    end
                end
                S_LOAD: begin
                    state <= S_STREAM;
                end
                S_STREAM: begin
                    if (stream_done) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (correlation_in_valid || (wait_cnt == '0)) begin
                        state <= S_COMPARE;
                    end
                end
                S_COMPARE: begin
                    if (last_hyp) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        state <= S_LOAD;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Sweep parameters, hypothesis index and the current SFO accumulator.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            num_hyp_r  <= '0;
            sfo_step_r <= '0;
            cur_sfo    <= '0;
            hyp_idx    <= '0;
        end else if (sweep_go) begin
            num_hyp_r  <= num_hyp;
            sfo_step_r <= sfo_step;
            cur_sfo    <= sfo_start;
            hyp_idx    <= '0;
        end else if ((state == S_COMPARE) && !last_hyp) begin
            hyp_idx <= hyp_idx + HYP_ONE;
            cur_sfo <= cur_sfo + sfo_step_r;
        end
    end

    // Bin replay: read address counter and the one-cycle update delay.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            bin_cnt  <= '0;
            update_r <= 1'b0;
        end else begin
            update_r <= bin_rd_en;
            if (state == S_LOAD) begin
                bin_cnt <= '0;
            end else if ((state == S_STREAM) && !stream_done) begin
                bin_cnt <= bin_cnt + BIN_CNT_ONE;
            end
        end
    end

    // Result capture: down-counting timeout, a timed-out hypothesis scores 0.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wait_cnt <= '0;
            result_r <= '0;
`ifdef SFO_SWEEP_METADATA_EN
            meta_r   <= '0;
`endif
        end else if ((state == S_STREAM) && stream_done) begin
            wait_cnt <= WAIT_LOAD;
        end else if (state == S_WAIT) begin
            if (correlation_in_valid) begin
                result_r <= correlation_in;
`ifdef SFO_SWEEP_METADATA_EN
                meta_r   <= metadata_in;
`endif
            end else if (wait_cnt == '0) begin
                result_r <= '0;
`ifdef SFO_SWEEP_METADATA_EN
                meta_r   <= '0;
`endif
            end else begin
                wait_cnt <= wait_cnt - WAIT_ONE;
            end
        end
    end

    // Argmax tracking; cleared by reset and by every accepted start.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            best_sfo      <= '0;
            best_corr     <= '0;
            best_index    <= '0;
`ifdef SFO_SWEEP_METADATA_EN
            best_metadata <= '0;
`endif
        end else if (sweep_go || sweep_empty) begin
            best_sfo      <= '0;
            best_corr     <= '0;
            best_index    <= '0;
`ifdef SFO_SWEEP_METADATA_EN
            best_metadata <= '0;
`endif
        end else if ((state == S_COMPARE) && take_best) begin
            best_sfo      <= cur_sfo;
            best_corr     <= result_r;
            best_index    <= hyp_idx;
`ifdef SFO_SWEEP_METADATA_EN
            best_metadata <= meta_r;
`endif
        end
    end

endmodule

// File: tb/tb_sfo_hypothesis_sweeper.sv
// Bench for sfo_hypothesis_sweeper with a 16-bin spectrum. A behavioural
// correlator and RAM respond to the DUT; a negedge monitor checks each cycle
// against a sweep model built from the chosen start/step/results.

module tb_sfo_hypothesis_sweeper;

    localparam int N  = 4;
    localparam int NB = 1 << N;
    localparam int PW = 16;
    localparam int SI = 9;
    localparam int SF = 16;
    localparam int CW = 26;
    localparam int HW = 8;
    localparam int TO = 64;
    localparam int SW = SI + SF;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          start = 1'b0;
    logic [SW-1:0] sfo_start = '0;
    logic [SW-1:0] sfo_step = '0;
    logic [HW-1:0] num_hyp = '0;
    logic          bin_rd_en;
    logic [N-1:0]  bin_rd_addr;
    logic [PW-1:0] bin_rd_data = '0;
    logic [SI-1:0] sfo_int_part;
    logic [SF-1:0] sfo_frac_part;
    logic          correlation_reset;
    logic          correlation_update;
    logic [PW-1:0] fft_mag_out;
    logic [CW-1:0] correlation_in = '0;
    logic          correlation_in_valid = 1'b0;
    logic          busy;
    logic          done;
    logic [SW-1:0] best_sfo;
    logic [CW-1:0] best_corr;
    logic [HW-1:0] best_index;

    sfo_hypothesis_sweeper #(
        .FFT_LEN_LOG2(N), .POWER_WIDTH(PW), .SFO_INT_WIDTH(SI), .SFO_FRAC_WIDTH(SF),
        .CORR_WIDTH(CW), .HYP_CNT_WIDTH(HW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .resetn(resetn), .start(start), .sfo_start(sfo_start),
        .sfo_step(sfo_step), .num_hyp(num_hyp), .bin_rd_en(bin_rd_en),
        .bin_rd_addr(bin_rd_addr), .bin_rd_data(bin_rd_data),
        .sfo_int_part(sfo_int_part), .sfo_frac_part(sfo_frac_part),
        .correlation_reset(correlation_reset), .correlation_update(correlation_update),
        .fft_mag_out(fft_mag_out), .correlation_in(correlation_in),
        .correlation_in_valid(correlation_in_valid), .busy(busy), .done(done),
        .best_sfo(best_sfo), .best_corr(best_corr), .best_index(best_index)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [PW-1:0] mem [NB];
    int            cfg_num = 0;
    logic [SW-1:0] cfg_start = '0;
    logic [SW-1:0] cfg_step = '0;
    logic [CW-1:0] res_tab [8];
    bit            never_tab [8];
    int            cfg_delay = 3;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [SW-1:0] exp_sfo(input int k);
        logic [SW-1:0] s;
        s = cfg_start;
        for (int i = 0; i < k; i++) s = s + cfg_step;
        return s;
    endfunction

    // Argmax over the chosen results; a timed-out hypothesis scores 0.
    task automatic model_best(output logic [HW-1:0] idx, output logic [CW-1:0] corr,
                              output logic [SW-1:0] sfo);
        logic [CW-1:0] r;
        idx = '0; corr = '0; sfo = '0;
        for (int i = 0; i < cfg_num; i++) begin
            r = never_tab[i] ? '0 : res_tab[i];
            if (i == 0 || r > corr) begin
                idx = HW'(i); corr = r; sfo = exp_sfo(i);
            end
        end
    endtask

    // Cycles from the start-sampling edge to the done cycle (negedge count).
    function automatic int exp_lat();
        int l;
        l = 1;
        for (int i = 0; i < cfg_num; i++) l += NB + 3 + (never_tab[i] ? TO : cfg_delay);
        return l;
    endfunction

    // Spectrum RAM, one cycle read latency.
    initial forever begin
        @(posedge clk);
        if (bin_rd_en) bin_rd_data <= mem[bin_rd_addr];
    end

    // Correlator: result valid cfg_delay cycles after the last update, held
    // until the next correlation_reset; never_tab hypotheses never complete.
    int cur_h = -1;
    int upd_seen = 0;
    int tgt = 0;
    bit pending = 1'b0;
    initial forever begin
        @(posedge clk);
        if (!resetn) begin
            cur_h = -1; upd_seen = 0; pending = 1'b0;
            correlation_in_valid <= 1'b0;
        end else if (correlation_reset) begin
            cur_h = cur_h + 1; upd_seen = 0; pending = 1'b0;
            correlation_in_valid <= 1'b0;
        end else begin
            if (done) cur_h = -1;
            if (pending) begin
                if (tgt <= 1) begin
                    correlation_in_valid <= 1'b1;
                    pending = 1'b0;
                end else begin
                    tgt = tgt - 1;
                end
            end
            if (correlation_update) begin
                upd_seen++;
                if (upd_seen == NB && cur_h >= 0 && cur_h < 8 && !never_tab[cur_h]) begin
                    correlation_in <= res_tab[cur_h];
                    if (cfg_delay <= 1) correlation_in_valid <= 1'b1;
                    else begin
                        pending = 1'b1;
                        tgt = cfg_delay - 1;
                    end
                end
            end
        end
    end

    // Per-cycle monitor against the sweep model.
    int hyp_k = 0;
    int rd_k = 0;
    int upd_k = 0;
    bit prev_rd = 1'b0;
    initial forever begin
        logic [HW-1:0] m_idx;
        logic [CW-1:0] m_corr;
        logic [SW-1:0] m_sfo;
        @(negedge clk);
        if (!resetn) begin
            chk("reset_corr_reset", correlation_reset, 1);
            hyp_k = 0; rd_k = 0; upd_k = 0; prev_rd = 1'b0;
        end else begin
            chk("update_after_read", correlation_update, prev_rd);
            if (correlation_reset) begin
                if (hyp_k > 0) chk("updates_per_hyp", upd_k, NB);
                chk("load_sfo", {sfo_int_part, sfo_frac_part}, exp_sfo(hyp_k));
                chk("load_busy", busy, 1);
                hyp_k++; rd_k = 0; upd_k = 0;
            end
            if (bin_rd_en) begin
                chk("rd_addr", bin_rd_addr, rd_k);
                rd_k++;
            end
            if (correlation_update) begin
                chk("fft_mag", fft_mag_out, mem[upd_k % NB]);
                chk("sfo_held", {sfo_int_part, sfo_frac_part}, exp_sfo(hyp_k - 1));
                upd_k++;
            end
            if (done) begin
                chk("done_busy", busy, 0);
                chk("hyp_count", hyp_k, cfg_num);
                if (hyp_k > 0) chk("updates_last_hyp", upd_k, NB);
                model_best(m_idx, m_corr, m_sfo);
                chk("best_index", best_index, m_idx);
                chk("best_corr", best_corr, m_corr);
                chk("best_sfo", best_sfo, m_sfo);
                hyp_k = 0; rd_k = 0; upd_k = 0;
            end
            prev_rd = bin_rd_en;
        end
    end

    task automatic setup_sweep(input int n, input logic [SW-1:0] s0, input logic [SW-1:0] st);
        cfg_num = n; cfg_start = s0; cfg_step = st;
        num_hyp = HW'(n); sfo_start = s0; sfo_step = st;
        for (int i = 0; i < 8; i++) begin
            res_tab[i] = '0;
            never_tab[i] = 1'b0;
        end
    endtask

    task automatic run_sweep(input string name, input int n_exp, input int inject);
        int got;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        got = -1;
        for (int c = 1; c <= n_exp + 100; c++) begin
            @(negedge clk);
            if (inject > 0 && c == inject) start = 1'b1;
            if (inject > 0 && c == inject + 1) start = 1'b0;
            if (done) begin
                got = c;
                break;
            end
        end
        chk({name, "_done_latency"}, got, n_exp);
        @(negedge clk);
        chk({name, "_done_single"}, done, 0);
    endtask

    initial begin
        int cnt;
        for (int i = 0; i < NB; i++) mem[i] = 16'h0a00 + 16'(i * 305);
        setup_sweep(0, '0, '0);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_best_sfo", best_sfo, 0);
        chk("rst_best_corr", best_corr, 0);
        chk("rst_best_index", best_index, 0);
        chk("rst_sfo", {sfo_int_part, sfo_frac_part}, 0);
        chk("rst_rd_en", bin_rd_en, 0);
        chk("rst_update", correlation_update, 0);
        chk("rst_mag", fft_mag_out, 0);
        @(posedge clk); #1 resetn = 1'b1;
        @(negedge clk);
        chk("idle_corr_reset", correlation_reset, 0);

        // num_hyp = 0: done next cycle, no reads, busy never rises
        setup_sweep(0, {9'd3, 16'h0}, '0);
        run_sweep("empty", 1, 0);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy || bin_rd_en) cnt++;
        end
        chk("empty_quiet", cnt, 0);

        // Single hypothesis, result 0x100 three cycles after last update
        setup_sweep(1, {9'd5, 16'h0}, '0);
        res_tab[0] = 26'h100;
        run_sweep("single", 23, 0);
        chk("single_best_corr", best_corr, 26'h100);
        chk("single_best_sfo", best_sfo, {9'd5, 16'h0});
        chk("single_best_index", best_index, 0);

        // Four hypotheses with a tie: earliest of the tied pair wins
        setup_sweep(4, {9'd4, 16'h8000}, {9'd0, 16'h4000});
        res_tab[0] = 10; res_tab[1] = 40; res_tab[2] = 40; res_tab[3] = 20;
        run_sweep("tie", exp_lat(), 0);
        chk("tie_best_index", best_index, 1);
        chk("tie_best_corr", best_corr, 40);
        chk("tie_best_sfo", best_sfo, {9'd4, 16'hc000});
        chk("tie_best_hold", busy, 0);

        // Hypothesis 2 of 3 times out and counts as 0
        setup_sweep(3, {9'd2, 16'h1000}, {9'd0, 16'h0800});
        res_tab[0] = 7; never_tab[1] = 1'b1; res_tab[2] = 3;
        run_sweep("timeout", 128, 0);
        chk("timeout_best_index", best_index, 0);
        chk("timeout_best_corr", best_corr, 7);
        chk("timeout_best_sfo", best_sfo, {9'd2, 16'h1000});

        // Start while busy is ignored
        setup_sweep(2, {9'd1, 16'hff00}, {9'd0, 16'h0200});
        res_tab[0] = 3; res_tab[1] = 3;
        run_sweep("busy_start", 45, 30);
        chk("busy_start_best_index", best_index, 0);
        chk("busy_start_best_sfo", best_sfo, {9'd1, 16'hff00});

        // Reset during STREAM of hypothesis 2
        setup_sweep(3, {9'd1, 16'h0}, {9'd0, 16'h0001});
        res_tab[0] = 50; res_tab[1] = 60; res_tab[2] = 70;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        cnt = 0;
        for (int i = 0; i < 200 && cnt < 2; i++) begin
            @(negedge clk);
            if (correlation_reset) cnt++;
        end
        chk("midrst_reached_hyp2", cnt, 2);
        repeat (5) @(negedge clk);
        chk("midrst_in_stream", bin_rd_en, 1);
        @(posedge clk); #1 resetn = 1'b0;
        @(negedge clk);
        chk("midrst_corr_reset", correlation_reset, 1);
        @(posedge clk); #1 resetn = 1'b1;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_best_corr", best_corr, 0);
        chk("midrst_best_sfo", best_sfo, 0);
        chk("midrst_best_index", best_index, 0);
        chk("midrst_sfo", {sfo_int_part, sfo_frac_part}, 0);
        chk("midrst_rd_en", bin_rd_en, 0);
        cnt = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (done || busy) cnt++;
        end
        chk("midrst_no_done", cnt, 0);

        // Fresh sweep after the abandoned one starts at hypothesis 0
        setup_sweep(2, {9'd7, 16'h0}, {9'd0, 16'h8000});
        res_tab[0] = 5; res_tab[1] = 9;
        run_sweep("fresh", exp_lat(), 0);
        chk("fresh_best_index", best_index, 1);
        chk("fresh_best_corr", best_corr, 9);
        chk("fresh_best_sfo", best_sfo, {9'd7, 16'h8000});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sfo_hypothesis_sweeper.md
Name: sfo_hypothesis_sweeper

Overview:
Sequencer that drives sfo_fft_correlator across a linear sweep of SFO hypotheses and tracks the best result. For each hypothesis it presents the SFO and pulses correlation reset. It then replays one stored power-spectrum (FFT magnitude bins, from an external 1-cycle-latency RAM) into the correlator and captures the returned correlation. It keeps the argmax and reports the winning SFO to the downstream timing-recovery logic.

Parameters:
FFT_LEN_LOG2, 9, log2 of bins replayed per hypothesis
POWER_WIDTH, 16, bin magnitude width
SFO_INT_WIDTH, 9, integer part of SFO hypothesis
SFO_FRAC_WIDTH, 16, fractional part of SFO hypothesis
CORR_WIDTH, 26, correlator output width (13 int + 13 frac)
HYP_CNT_WIDTH, 8, width of hypothesis count/index
TIMEOUT_CYCLES, 64, max wait for correlator result after last bin

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
start  in  1  single-cycle pulse; begins a sweep when idle
sfo_start  in  SFO_INT_WIDTH+SFO_FRAC_WIDTH  first hypothesis {int,frac}
sfo_step  in  SFO_INT_WIDTH+SFO_FRAC_WIDTH  hypothesis increment {int,frac}
num_hyp  in  HYP_CNT_WIDTH  number of hypotheses to test
bin_rd_en  out  1  RAM read enable
bin_rd_addr  out  FFT_LEN_LOG2  RAM read address
bin_rd_data  in  POWER_WIDTH  RAM data, valid 1 cycle after bin_rd_en
sfo_int_part  out  SFO_INT_WIDTH  to correlator
sfo_frac_part  out  SFO_FRAC_WIDTH  to correlator
correlation_reset  out  1  to correlator
correlation_update  out  1  to correlator
fft_mag_out  out  POWER_WIDTH  to correlator fft_mag_in
correlation_in  in  CORR_WIDTH  from correlator
correlation_in_valid  in  1  from correlator; level, held until its reset
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at sweep end
best_sfo  out  SFO_INT_WIDTH+SFO_FRAC_WIDTH  winning hypothesis
best_corr  out  CORR_WIDTH  winning correlation
best_index  out  HYP_CNT_WIDTH  index of winning hypothesis

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on resetn.
- Reset (resetn=0 at posedge): state IDLE. All outputs are 0, including best_* and the SFO outputs, with one exception: correlation_reset is held 1 during reset so the correlator is cleared.
- Reset mid-sweep: the sweep is abandoned. No done pulse. best_* is cleared.
- IDLE:
  - start=1 and num_hyp!=0: latch inputs, hyp_idx=0, cur_sfo=sfo_start, clear best_*, busy=1, go to LOAD.
  - start=1 and num_hyp==0: pulse done the next cycle, best_* stays 0, busy never rises.
  - start while busy is ignored.
- LOAD (1 cycle):
  - correlation_reset=1.
  - sfo_int_part/sfo_frac_part = cur_sfo. These are driven from registers and held constant from LOAD through COMPARE.
  - Next state: STREAM.
- STREAM:
  - bin_rd_en=1 with addresses 0..2^FFT_LEN_LOG2-1 on consecutive cycles.
  - The cycle after each read: correlation_update=1 and fft_mag_out=bin_rd_data. fft_mag_out is registered as the RAM data; no extra latency is allowed.
  - Exactly 2^FFT_LEN_LOG2 update pulses, no gaps. Duration is 2^FFT_LEN_LOG2+1 cycles.
  - Next state: WAIT.
- WAIT:
  - correlation_in_valid=1: sample correlation_in and go to COMPARE.
  - Wait counter reaches TIMEOUT_CYCLES: result is taken as 0 and the state goes to COMPARE. This covers a correlator that never completes because its harmonics exceed the spectrum.
- COMPARE (1 cycle):
  - result > best_corr (unsigned, strict): best_corr=result, best_sfo=cur_sfo, best_index=hyp_idx. Ties keep the earlier hypothesis.
  - The first hypothesis always loads best_*, even when its result is 0.
  - hyp_idx==num_hyp-1: done=1 and busy=0 in the same cycle, go to IDLE.
  - Otherwise: hyp_idx+1, cur_sfo+=sfo_step, go to LOAD.
- cur_sfo arithmetic: one (SFO_INT_WIDTH+SFO_FRAC_WIDTH)-bit unsigned add; frac carries into int. Overflow wraps modulo 2^(SFO_INT_WIDTH+SFO_FRAC_WIDTH) with no flag.
- best_* outputs are stable outside COMPARE and hold after done until the next accepted start.
- Per-hypothesis cycles: 1 + (2^N+1) + wait + 1.

Optional Feature:
SFO_SWEEP_METADATA_EN: when defined, adds these ports:
- metadata_in, input, 2*POWER_WIDTH: sampled alongside correlation_in.
- best_metadata, output, 2*POWER_WIDTH: updated together with best_corr, cleared on reset and on start, 0 on timeout.

When undefined, both ports are absent and no metadata registers are instantiated.

Test Plan:
- FFT_LEN_LOG2=4, num_hyp=1, sfo_start={5,0}, correlator model returns 0x100 three cycles after the last update -> exactly 16 update pulses fed bins 0..15 in order, one correlation_reset before them, best_corr=0x100, best_sfo={5,0}, best_index=0, done pulse once.
- num_hyp=4, sfo_start={4,0x8000}, step={0,0x4000}, model results 10,40,40,20 -> SFO outputs are {4,8000},{4,C000},{5,0000},{5,4000}; best_index=1 (tie keeps first), best_corr=40, best_sfo={4,0xC000}.
- Model never asserts valid on hypothesis 2 of 3, results 7,–,3 -> hypothesis 2 takes TIMEOUT_CYCLES then counts as 0; best_index=0, best_corr=7.
- num_hyp=0 with start -> done on the next cycle, busy stays 0, no RAM reads.
- resetn low for one cycle while in STREAM of hypothesis 2, then start pulsed again -> outputs clear, no done pulse, correlation_reset is 1 during reset; the fresh sweep restarts at hyp_idx 0.
- start pulsed while busy -> ignored; the sweep's hypothesis count and done timing are unchanged.
